// File: rtl/sp_request_queue_pkg.sv
// Shared types and helpers for the scratchpad request queue.
package sp_request_queue_pkg;

   typedef enum logic [1:0] {
      SP_ILLEGAL = 2'b00,
      SP_LOAD    = 2'b01,
      SP_STORE   = 2'b10,
      SP_GEMM    = 2'b11
   } sp_op_t;

   localparam int unsigned SP_TAG_W    = 4;
   localparam int unsigned SP_STRIDE_W = 5;

   // Scratchpad entry layout at the default 32-bit payload width (43 bits).
   typedef struct packed {
      sp_op_t      op;
      logic [3:0]  tag;
      logic [31:0] payload;
      logic [4:0]  stride;
   } sp_entry_t;

   // Packed entry width {op, tag, payload, stride} for a given payload width.
   function automatic int unsigned sp_entry_width(input int unsigned addr_w);
      return 2 + SP_TAG_W + addr_w + SP_STRIDE_W;
   endfunction

endpackage

// File: rtl/sp_request_queue_if.sv
// Producer-side request channels and consumer-side dequeue port of the queue.
interface sp_request_queue_if #(
   parameter int unsigned NCH    = 2,
   parameter int unsigned ADDR_W = 32
);
   import sp_request_queue_pkg::*;

   localparam int unsigned ENTRY_W = sp_entry_width(ADDR_W);

   logic [NCH-1:0]             req_valid;
   logic [NCH-1:0]             req_ready;
   logic [NCH-1:0][1:0]        req_op;
   logic [NCH-1:0][3:0]        req_tag;
   logic [NCH-1:0][ADDR_W-1:0] req_payload;
   logic [NCH-1:0][4:0]        req_stride;

   logic                       deq_valid;
   logic                       deq_ready;
   logic [ENTRY_W-1:0]         deq_data;

   modport master (
      output req_valid, req_op, req_tag, req_payload, req_stride, deq_ready,
      input  req_ready, deq_valid, deq_data
   );

   modport slave (
      input  req_valid, req_op, req_tag, req_payload, req_stride, deq_ready,
      output req_ready, deq_valid, deq_data
   );

endinterface

// File: rtl/sp_request_queue_rr_arbiter.sv
// Combinational round-robin arbiter; the rotating pointer lives in the caller.
module rr_arbiter #(
   parameter  int unsigned N     = 2,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic             en,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic        found;
   int unsigned idx;

   // Pick the first requester at or after rr_ptr, wrapping modulo N.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/sp_request_queue.sv
// Multi-channel scratchpad request queue: round-robin enqueue, FIFO drain.
module sp_request_queue
   import sp_request_queue_pkg::*;
#(
   parameter int unsigned NCH      = 2,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned AF_LEVEL = DEPTH - 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   sp_request_queue_if.slave        bus,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     almost_full,
   output logic                     illegal_op
);

   localparam int unsigned ENTRY_W = sp_entry_width(ADDR_W);
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [IDX_W-1:0]   rr_ptr, rr_nxt, gnt_idx;
   logic [NCH-1:0]     gnt;
   logic               any_gnt, enq, deq;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [ENTRY_W-1:0] wr_entry;

   // Grant only from registered full so deq_ready never reaches req_ready.
   rr_arbiter #(.N(NCH)) u_arb (
      .req     (bus.req_valid),
      .en      (!full && !flush),
      .rr_ptr  (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign bus.req_ready = gnt;
   assign any_gnt       = |gnt;
   assign enq           = any_gnt && (sp_op_t'(bus.req_op[gnt_idx]) != SP_ILLEGAL);
   assign deq           = bus.deq_valid && bus.deq_ready;
   assign rr_nxt        = (32'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + IDX_W'(1);
   assign wr_entry      = {bus.req_op[gnt_idx], bus.req_tag[gnt_idx],
                           bus.req_payload[gnt_idx], bus.req_stride[gnt_idx]};

   assign bus.deq_valid = (count != '0);
   assign bus.deq_data  = mem[rd_ptr];

   // Next occupancy from this cycle's enqueue/dequeue pair.
   always_comb begin
      cnt_nxt = count;
      if (enq && !deq)      cnt_nxt = count + CNT_W'(1);
      else if (!enq && deq) cnt_nxt = count - CNT_W'(1);
   end

   // Control state: reset beats flush beats traffic; flush keeps rr_ptr and illegal_op.
   always_ff @(posedge CLK) begin
      if (RST) begin
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rr_ptr      <= '0;
         full        <= 1'b0;
         almost_full <= (AF_LEVEL == 0);
         illegal_op  <= 1'b0;
      end else if (flush) begin
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         full        <= 1'b0;
         almost_full <= (AF_LEVEL == 0);
      end else begin
         if (enq)            wr_ptr     <= wr_ptr + PTR_W'(1);
         if (deq)            rd_ptr     <= rd_ptr + PTR_W'(1);
         if (any_gnt)        rr_ptr     <= rr_nxt;
         if (any_gnt && !enq) illegal_op <= 1'b1;
         count       <= cnt_nxt;
         full        <= (cnt_nxt == CNT_W'(DEPTH));
         almost_full <= (cnt_nxt >= CNT_W'(AF_LEVEL));
      end
   end

   // Entry storage; contents need no reset since deq_valid gates them.
   always_ff @(posedge CLK) begin
      if (enq) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: tb/tb_sp_request_queue.sv
// Directed bench for sp_request_queue (NCH=2, DEPTH=8, ADDR_W=32, AF_LEVEL=6).
module tb_sp_request_queue;
   import sp_request_queue_pkg::*;

   logic       CLK = 1'b0;
   logic       RST;
   logic       flush;
   logic [3:0] count;
   logic       full, almost_full, illegal_op;
   int         n_checks = 0;
   int         n_errors = 0;

   sp_request_queue_if #(.NCH(2), .ADDR_W(32)) bus ();

   sp_request_queue #(.NCH(2), .DEPTH(8), .ADDR_W(32), .AF_LEVEL(6)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .bus         (bus),
      .flush       (flush),
      .count       (count),
      .full        (full),
      .almost_full (almost_full),
      .illegal_op  (illegal_op)
   );

   always #5 CLK = ~CLK;

   function automatic logic [42:0] ent(input logic [1:0] op, input logic [3:0] tag,
                                       input logic [31:0] pl, input logic [4:0] st);
      return {op, tag, pl, st};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_ch(input int unsigned ch, input logic [1:0] op, input logic [3:0] tag,
                         input logic [31:0] pl, input logic [4:0] st);
      bus.req_valid[ch]   = 1'b1;
      bus.req_op[ch]      = op;
      bus.req_tag[ch]     = tag;
      bus.req_payload[ch] = pl;
      bus.req_stride[ch]  = st;
   endtask

   task automatic idle();
      bus.req_valid = '0;
   endtask

   initial begin
      RST             = 1'b1;
      flush           = 1'b0;
      bus.req_valid   = '0;
      bus.req_op      = '0;
      bus.req_tag     = '0;
      bus.req_payload = '0;
      bus.req_stride  = '0;
      bus.deq_ready   = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_illegal", illegal_op, 0);
      chk("rst_deq_valid", bus.deq_valid, 0);
      RST = 1'b0;
      #1;
      chk("rst_req_ready", bus.req_ready, 2'b00);
      tick();

      // Single MLS load; no fall-through in the push cycle
      set_ch(0, 2'b01, 4'd3, 32'h1000_0040, 5'd4);
      #1;
      chk("load_ready", bus.req_ready, 2'b01);
      chk("load_no_fallthru", bus.deq_valid, 0);
      tick();
      idle();
      chk("load_deq_valid", bus.deq_valid, 1);
      chk("load_deq_data", bus.deq_data, ent(2'b01, 4'd3, 32'h1000_0040, 5'd4));
      chk("load_count", count, 1);
      bus.deq_ready = 1'b1;
      tick();
      chk("load_pop_count", count, 0);
      chk("load_pop_valid", bus.deq_valid, 0);

      // Both channels: rr_ptr is 1 after the ch0 grant, so grants go 1,0,1,0
      for (int unsigned i = 0; i < 4; i++) begin
         set_ch(0, 2'b01, 4'd2, 32'hA000_0000 + i, 5'd3);
         set_ch(1, 2'b11, 4'h8, 32'h0000_0100 + i, 5'd0);
         #1;
         chk("alt_ready", bus.req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
         tick();
         chk("alt_count", count, 1);
         chk("alt_data", bus.deq_data, (i % 2 == 0) ? ent(2'b11, 4'h8, 32'h0000_0100 + i, 5'd0)
                                                     : ent(2'b01, 4'd2, 32'hA000_0000 + i, 5'd3));
      end
      idle();
      tick();
      chk("alt_drain", count, 0);
      bus.deq_ready = 1'b0;

      // Zero the pointers, then fill to full
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         set_ch(0, 2'b01, 4'd5, 32'h100 + i, 5'd1);
         #1;
         chk("fill_ready", bus.req_ready, 2'b01);
         tick();
         chk("fill_count", count, i + 1);
         chk("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
         chk("fill_full", full, (i + 1 == 8) ? 1 : 0);
      end
      set_ch(0, 2'b01, 4'd5, 32'h108, 5'd1);
      #1;
      chk("full_ready", bus.req_ready, 2'b00);
      bus.deq_ready = 1'b1;
      #1;
      chk("full_pop_ready", bus.req_ready, 2'b00);
      tick();
      chk("pop1_count", count, 7);
      chk("pop1_full", full, 0);
      chk("pop1_head", bus.deq_data, ent(2'b01, 4'd5, 32'h101, 5'd1));
      bus.deq_ready = 1'b0;
      #1;
      chk("refill_ready", bus.req_ready, 2'b01);
      tick();
      idle();
      chk("refill_count", count, 8);
      chk("refill_full", full, 1);
      bus.deq_ready = 1'b1;
      for (int unsigned j = 1; j <= 8; j++) begin
         chk("drain_valid", bus.deq_valid, 1);
         chk("drain_data", bus.deq_data, ent(2'b01, 4'd5, 32'h100 + j, 5'd1));
         tick();
      end
      chk("drain_count", count, 0);
      bus.deq_ready = 1'b0;

      // Flush with 5 queued, racing with valid and deq_ready
      for (int unsigned i = 0; i < 5; i++) begin
         set_ch(0, 2'b10, 4'd6, 32'h200 + i, 5'd2);
         tick();
      end
      chk("pre_flush_count", count, 5);
      set_ch(1, 2'b11, 4'h8, 32'h0000_0055, 5'd0);
      flush = 1'b1;
      bus.deq_ready = 1'b1;
      #1;
      chk("flush_ready", bus.req_ready, 2'b00);
      tick();
      chk("flush_count", count, 0);
      chk("flush_valid", bus.deq_valid, 0);
      chk("flush_af", almost_full, 0);
      flush = 1'b0;
      bus.deq_ready = 1'b0;
      #1;
      chk("flush_rr_kept", bus.req_ready, 2'b10);
      tick();
      idle();
      chk("post_flush_count", count, 1);
      chk("post_flush_data", bus.deq_data, ent(2'b11, 4'h8, 32'h0000_0055, 5'd0));
      bus.deq_ready = 1'b1;
      tick();
      bus.deq_ready = 1'b0;

      // Illegal op is consumed but not stored; sticky through flush
      set_ch(1, 2'b00, 4'd0, 32'h77, 5'd0);
      #1;
      chk("ill_ready", bus.req_ready, 2'b10);
      tick();
      idle();
      chk("ill_count", count, 0);
      chk("ill_flag", illegal_op, 1);
      chk("ill_valid", bus.deq_valid, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("ill_after_flush", illegal_op, 1);

      // Reset mid-traffic with 3 queued
      for (int unsigned i = 0; i < 3; i++) begin
         set_ch(0, 2'b01, 4'd7, 32'h300 + i, 5'd3);
         tick();
      end
      chk("pre_rst_count", count, 3);
      bus.deq_ready = 1'b1;
      RST = 1'b1;
      tick();
      idle();
      bus.deq_ready = 1'b0;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_valid", bus.deq_valid, 0);
      chk("mid_rst_illegal", illegal_op, 0);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_af", almost_full, 0);
      RST = 1'b0;
      set_ch(0, 2'b01, 4'd9, 32'h400, 5'd1);
      set_ch(1, 2'b11, 4'h8, 32'h66, 5'd0);
      #1;
      chk("post_rst_rr", bus.req_ready, 2'b01);
      tick();
      idle();
      chk("post_rst_count", count, 1);
      chk("post_rst_data", bus.deq_data, ent(2'b01, 4'd9, 32'h400, 5'd1));
      bus.deq_ready = 1'b1;
      tick();
      chk("post_rst_drain", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
